// File: rtl/window_gen_3x3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_gen_3x3 : raster pixel stream -> 3x3 neighbourhood per interior px |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module window_gen_3x3 #(
  parameter int ROWS = 5,
  parameter int COLS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_i,
  input  logic [7:0] pixel_i,
  output logic [7:0] d0_o,
  output logic [7:0] d1_o,
  output logic [7:0] d2_o,
  output logic [7:0] d3_o,
  output logic [7:0] d4_o,
  output logic [7:0] d5_o,
  output logic [7:0] d6_o,
  output logic [7:0] d7_o,
  output logic [7:0] d8_o,
  output logic       done_o,
  output logic       frame_done_o
);

  localparam int C_COL_W = $clog2(COLS);
  localparam int C_ROW_W = $clog2(ROWS);
  localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(COLS - 1);
  localparam logic [C_COL_W-1:0] C_COL_TWO  = C_COL_W'(2);
  localparam logic [C_COL_W-1:0] C_COL_ONE  = C_COL_W'(1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(ROWS - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_TWO  = C_ROW_W'(2);
  localparam logic [C_ROW_W-1:0] C_ROW_ONE  = C_ROW_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [C_COL_W-1:0]   r_col;
  logic [C_ROW_W-1:0]   r_row;
  logic [7:0]           r_lb0 [COLS];
  logic [7:0]           r_lb1 [COLS];
  logic [7:0]           r_win [9];
  logic [7:0]           r_dout [9];
  logic [7:0]           w_shift [9];
  logic [7:0]           w_top;
  logic [7:0]           w_mid;
  logic                 r_done;
  logic                 r_frame_done;
  logic                 w_col_last;
  logic                 w_frame_last;
  logic                 w_emit;

  assign w_top        = r_lb0[r_col];
  assign w_mid        = r_lb1[r_col];
  assign w_col_last   = (r_col == C_COL_LAST);
  assign w_frame_last = w_col_last && (r_row == C_ROW_LAST);
  assign w_emit       = done_i && (r_row >= C_ROW_TWO) && (r_col >= C_COL_TWO);

  // Window as it will look after this pixel is accepted; d0 oldest, d8 newest.
  always_comb begin
    w_shift[0] = r_win[1];
    w_shift[1] = r_win[2];
    w_shift[2] = w_top;
    w_shift[3] = r_win[4];
    w_shift[4] = r_win[5];
    w_shift[5] = w_mid;
    w_shift[6] = r_win[7];
    w_shift[7] = r_win[8];
    w_shift[8] = pixel_i;
  end

  // Storage is never emitted before being refilled, so it carries no reset.
  always_ff @(posedge clk) begin
    if (done_i) begin
      r_lb0[r_col] <= w_mid;
      r_lb1[r_col] <= pixel_i;
      r_win        <= w_shift;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (done_i) w_state_next = S_FILL;
      S_FILL: if (done_i && (r_row == C_ROW_TWO) && (r_col == '0)) w_state_next = S_RUN;
      S_RUN:  if (done_i && w_frame_last) w_state_next = S_DONE;
      S_DONE: w_state_next = done_i ? S_FILL : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_done       <= 1'b0;
      r_frame_done <= 1'b0;
      r_dout       <= '{default: 8'd0};
    end else begin
      r_state      <= w_state_next;
      r_done       <= w_emit;
      r_frame_done <= (r_state == S_DONE);
      if (w_emit) begin
        r_dout <= w_shift;
      end
      if (done_i) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + C_ROW_ONE;
        end else begin
          r_col <= r_col + C_COL_ONE;
        end
      end
    end
  end

  assign d0_o         = r_dout[0];
  assign d1_o         = r_dout[1];
  assign d2_o         = r_dout[2];
  assign d3_o         = r_dout[3];
  assign d4_o         = r_dout[4];
  assign d5_o         = r_dout[5];
  assign d6_o         = r_dout[6];
  assign d7_o         = r_dout[7];
  assign d8_o         = r_dout[8];
  assign done_o       = r_done;
  assign frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_window_gen_3x3 : directed/random stream against a frame-array model    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_window_gen_3x3;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int NPIX = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done_i = 1'b0;
  logic [7:0] pixel_i = 8'd0;
  logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
  logic       done_o;
  logic       frame_done_o;

  always #5 clk = ~clk;

  window_gen_3x3 #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .pixel_i(pixel_i),
    .d0_o(d0_o), .d1_o(d1_o), .d2_o(d2_o), .d3_o(d3_o), .d4_o(d4_o),
    .d5_o(d5_o), .d6_o(d6_o), .d7_o(d7_o), .d8_o(d8_o),
    .done_o(done_o), .frame_done_o(frame_done_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the frame as sent, plus the expected registered outputs.
  logic [7:0]  img [ROWS][COLS];
  int          n = 0;
  logic        m_done = 1'b0;
  logic        m_fd = 1'b0;
  logic        m_lastacc = 1'b0;
  logic [71:0] m_win = '0;
  logic [71:0] obs_q [$];
  int          fd_seen = 0;

  logic [71:0] obs_win;
  assign obs_win = {d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o};

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check what the previous edge produced, then drive the next input.
  task automatic step(input logic v, input logic [7:0] p);
    int r;
    int c;
    @(negedge clk);
    chk("done_o", {71'b0, done_o}, {71'b0, m_done});
    chk("frame_done_o", {71'b0, frame_done_o}, {71'b0, m_fd});
    chk("window", obs_win, m_win);
    if (done_o === 1'b1) obs_q.push_back(obs_win);
    if (frame_done_o === 1'b1) fd_seen++;
    done_i  = v;
    pixel_i = p;
    m_fd      = m_lastacc;
    m_lastacc = 1'b0;
    m_done    = 1'b0;
    if (v) begin
      r = n / COLS;
      c = n % COLS;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        m_done = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            m_win[71 - 8*(3*i + j) -: 8] = img[r-2+i][c-2+j];
      end
      m_lastacc = (n == NPIX - 1);
      n = (n + 1) % NPIX;
    end
  endtask

  // Sends pixels [from, to) of a frame; pattern value base+k+1 or random.
  task automatic send(input int base, input int from, input int to,
                      input int maxgap, input bit rnd);
    int g;
    for (int k = from; k < to; k++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int i = 0; i < g; i++) step(1'b0, 8'($urandom));
      step(1'b1, rnd ? 8'($urandom) : 8'(base + k + 1));
    end
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    done_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_window", obs_win, 72'd0);
      chk("rst_done", {71'b0, done_o}, 72'd0);
      chk("rst_frame_done", {71'b0, frame_done_o}, 72'd0);
      @(negedge clk);
    end
    rst       = 1'b1;
    n         = 0;
    m_done    = 1'b0;
    m_fd      = 1'b0;
    m_lastacc = 1'b0;
    m_win     = '0;
    obs_q.delete();
    fd_seen   = 0;
  endtask

  initial begin
    // Test 1: contiguous frame, directed windows against literal values.
    do_reset();
    send(0, 0, NPIX, 0, 1'b0);
    idle(4);
    chk("t1_count", 72'(obs_q.size()), 72'd9);
    chk("t1_first", obs_q[0], 72'h01_02_03_06_07_08_0B_0C_0D);
    chk("t1_last",  obs_q[8], 72'h0D_0E_0F_12_13_14_17_18_19);
    chk("t1_fd_count", 72'(fd_seen), 72'd1);

    // Test 2: same frame with random 0-3 idle gaps.
    do_reset();
    send(0, 0, NPIX, 3, 1'b0);
    idle(4);
    chk("t2_count", 72'(obs_q.size()), 72'd9);
    chk("t2_first", obs_q[0], 72'h01_02_03_06_07_08_0B_0C_0D);
    chk("t2_last",  obs_q[8], 72'h0D_0E_0F_12_13_14_17_18_19);

    // Test 3: back-to-back frames, second offset by 100.
    do_reset();
    send(0, 0, NPIX, 0, 1'b0);
    send(100, 0, NPIX, 0, 1'b0);
    idle(4);
    chk("t3_count", 72'(obs_q.size()), 72'd18);
    chk("t3_f2_first", obs_q[9], 72'h65_66_67_6A_6B_6C_6F_70_71);
    chk("t3_fd_count", 72'(fd_seen), 72'd2);

    // Test 4: reset after pixel 17, then a full fresh frame.
    do_reset();
    send(0, 0, 17, 0, 1'b0);
    do_reset();
    send(0, 0, 12, 0, 1'b0);
    chk("t4_none_early", 72'(obs_q.size()), 72'd0);
    send(0, 12, NPIX, 1, 1'b0);
    idle(4);
    chk("t4_count", 72'(obs_q.size()), 72'd9);
    chk("t4_first", obs_q[0], 72'h01_02_03_06_07_08_0B_0C_0D);

    // Test 6: 50-cycle stall mid-row 3, random pixel data.
    do_reset();
    send(0, 0, 17, 0, 1'b1);
    idle(50);
    send(0, 17, NPIX, 0, 1'b1);
    idle(4);
    chk("t6_count", 72'(obs_q.size()), 72'd9);

    // Random frames with random gaps, back to back (test 5 timing via model).
    do_reset();
    for (int f = 0; f < 4; f++) send(0, 0, NPIX, (f == 1) ? 0 : 2, 1'b1);
    idle(4);
    chk("rnd_count", 72'(obs_q.size()), 72'd36);
    chk("rnd_fd_count", 72'(fd_seen), 72'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
